// File: rtl/trig_pkg.sv
// Shared types and widths for the camera trigger/ready responder.
package trig_pkg;

  localparam int unsigned TMR_W = 16;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_EXPOSE  = 2'b01,
    ST_READOUT = 2'b10,
    ST_RDY     = 2'b11
  } state_e;

  // Down-counter load value so a phase lasts exactly cyc cycles.
  function automatic logic [TMR_W-1:0] tmr_load(input int unsigned cyc);
    return TMR_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer with a delayed copy for rising-edge detection.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise_c
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= din;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign rise_c = r_s2 & ~r_s3;

endmodule

// File: rtl/trig_rdy_responder.sv
// Camera emulator: trig -> expose -> readout -> rdy pulse, with frame/missed stats.
module trig_rdy_responder
  import trig_pkg::*;
#(
  parameter int unsigned EXPO_CYC = 1000,
  parameter int unsigned READ_CYC = 5000,
  parameter int unsigned RDY_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic             en,
  input  logic             clr_stats,
  output logic             rdy,
  output logic             busy,
  output logic             exposing,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] missed_cnt
);

  logic             w_rise;
  logic             w_tmr_zero;
  logic             w_frame_done;
  state_e           r_state;
  state_e           w_state_nxt;
  logic [TMR_W-1:0] r_tmr;
  logic [TMR_W-1:0] w_tmr_nxt;
  logic             r_rdy;
  logic             r_busy;
  logic             r_exposing;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [CNT_W-1:0] r_missed_cnt;

  edge_sync u_trig_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (trig),
    .rise_c (w_rise)
  );

  assign w_tmr_zero = (r_tmr == '0);

  // Next-state and timer reload/decrement.
  always_comb begin
    w_state_nxt  = r_state;
    w_tmr_nxt    = r_tmr;
    w_frame_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise && en) begin
          w_state_nxt = ST_EXPOSE;
          w_tmr_nxt   = tmr_load(EXPO_CYC);
        end
      end
      ST_EXPOSE: begin
        if (w_tmr_zero) begin
          w_state_nxt = ST_READOUT;
          w_tmr_nxt   = tmr_load(READ_CYC);
        end else begin
          w_tmr_nxt = r_tmr - TMR_W'(1);
        end
      end
      ST_READOUT: begin
        if (w_tmr_zero) begin
          w_state_nxt = ST_RDY;
          w_tmr_nxt   = tmr_load(RDY_W);
        end else begin
          w_tmr_nxt = r_tmr - TMR_W'(1);
        end
      end
      ST_RDY: begin
        if (w_tmr_zero) begin
          w_state_nxt  = ST_IDLE;
          w_frame_done = 1'b1;
        end else begin
          w_tmr_nxt = r_tmr - TMR_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tmr_nxt   = '0;
      end
    endcase
  end

  // State, timer and outputs decoded from the next state so they move together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_tmr      <= '0;
      r_rdy      <= 1'b0;
      r_busy     <= 1'b0;
      r_exposing <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tmr      <= w_tmr_nxt;
      r_rdy      <= (w_state_nxt == ST_RDY);
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_exposing <= (w_state_nxt == ST_EXPOSE);
    end
  end

  // Frame counter wraps; missed counter saturates; clear beats increment.
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      r_frame_cnt  <= '0;
      r_missed_cnt <= '0;
    end else begin
      if (w_frame_done) begin
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end
      if (w_rise && (r_state != ST_IDLE) && (r_missed_cnt != '1)) begin
        r_missed_cnt <= r_missed_cnt + CNT_W'(1);
      end
    end
  end

  assign rdy        = r_rdy;
  assign busy       = r_busy;
  assign exposing   = r_exposing;
  assign frame_cnt  = r_frame_cnt;
  assign missed_cnt = r_missed_cnt;

endmodule

// File: tb/tb_trig_rdy_responder.sv
// Self-checking bench: vector table, random vs. timeline model, and corner sequences.
module tb_trig_rdy_responder;

  localparam int unsigned A_E = 4;
  localparam int unsigned A_R = 6;
  localparam int unsigned A_W = 2;
  localparam int unsigned A_TOTAL = A_E + A_R + A_W;

  logic clk;
  int   vectors;
  int   miscompares;

  logic a_rst, a_trig, a_en, a_clr, a_rdy, a_busy, a_expo;
  logic [7:0] a_frame, a_missed;
  logic b_rst, b_trig, b_en, b_clr, b_rdy, b_busy, b_expo;
  logic [7:0] b_frame, b_missed;
  logic c_rst, c_trig, c_en, c_clr, c_rdy, c_busy, c_expo;
  logic [7:0] c_frame, c_missed;

  trig_rdy_responder #(.EXPO_CYC(A_E), .READ_CYC(A_R), .RDY_W(A_W)) dut_a (
    .clk(clk), .rst(a_rst), .trig(a_trig), .en(a_en), .clr_stats(a_clr),
    .rdy(a_rdy), .busy(a_busy), .exposing(a_expo),
    .frame_cnt(a_frame), .missed_cnt(a_missed));

  trig_rdy_responder #(.EXPO_CYC(2000), .READ_CYC(2000), .RDY_W(2)) dut_b (
    .clk(clk), .rst(b_rst), .trig(b_trig), .en(b_en), .clr_stats(b_clr),
    .rdy(b_rdy), .busy(b_busy), .exposing(b_expo),
    .frame_cnt(b_frame), .missed_cnt(b_missed));

  trig_rdy_responder #(.EXPO_CYC(1), .READ_CYC(1), .RDY_W(1)) dut_c (
    .clk(clk), .rst(c_rst), .trig(c_trig), .en(c_en), .clr_stats(c_clr),
    .rdy(c_rdy), .busy(c_busy), .exposing(c_expo),
    .frame_cnt(c_frame), .missed_cnt(c_missed));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst, trig, en, clr;
    int         ncyc;
    logic       rdy, busy, expo;
    logic [7:0] frame, missed;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic r, t, e, c, input int n,
                             input logic xr, xb, xe, input int xf, xm);
    vec_t x;
    x.rst = r; x.trig = t; x.en = e; x.clr = c; x.ncyc = n;
    x.rdy = xr; x.busy = xb; x.expo = xe; x.frame = 8'(xf); x.missed = 8'(xm);
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Timeline model: a frame is the busy window after acceptance; phases are offsets.
  int unsigned m_left;
  bit [3:0]    m_smp;
  bit [7:0]    m_frame, m_missed;

  task automatic model_step(input bit r, t, e, c);
    bit rise, done;
    if (r) begin
      m_smp = '0; m_left = 0; m_frame = 0; m_missed = 0;
    end else begin
      m_smp = {m_smp[2:0], t};
      rise  = m_smp[2] && !m_smp[3];
      done  = (m_left == 1);
      if (m_left > 0) begin
        if (rise && m_missed != 8'd255) m_missed = m_missed + 8'd1;
        m_left = m_left - 1;
      end else if (rise && e) begin
        m_left = A_TOTAL;
      end
      if (done) m_frame = m_frame + 8'd1;
      if (c) begin m_frame = 0; m_missed = 0; end
    end
  endtask

  initial begin
    int el;
    int rdy_cnt;
    bit exp_busy, exp_expo, exp_rdy;
    vectors = 0; miscompares = 0;
    a_rst = 1; a_trig = 0; a_en = 1; a_clr = 0;
    b_rst = 1; b_trig = 0; b_en = 1; b_clr = 0;
    c_rst = 1; c_trig = 0; c_en = 1; c_clr = 0;

    // rst trig en clr n | rdy busy expo frame missed
    tbl.push_back(v(1,0,1,0, 2, 0,0,0, 0,0));
    tbl.push_back(v(0,1,1,0, 2, 0,0,0, 0,0));
    tbl.push_back(v(0,1,1,0, 1, 0,1,1, 0,0));
    tbl.push_back(v(0,0,1,0, 3, 0,1,1, 0,0));
    tbl.push_back(v(0,0,1,0, 1, 0,1,0, 0,0));
    tbl.push_back(v(0,0,1,0, 5, 0,1,0, 0,0));
    tbl.push_back(v(0,0,1,0, 1, 1,1,0, 0,0));
    tbl.push_back(v(0,0,1,0, 1, 1,1,0, 0,0));
    tbl.push_back(v(0,0,1,0, 1, 0,0,0, 1,0));
    tbl.push_back(v(0,1,1,0, 3, 0,1,1, 1,0));
    tbl.push_back(v(0,0,1,0, 4, 0,1,0, 1,0));
    tbl.push_back(v(0,1,1,0, 3, 0,1,0, 1,1));
    tbl.push_back(v(0,0,1,0, 5, 0,0,0, 2,1));
    tbl.push_back(v(0,1,1,0, 3, 0,1,1, 2,1));
    tbl.push_back(v(0,0,1,0,11, 1,1,0, 2,1));
    tbl.push_back(v(0,0,1,0, 1, 0,0,0, 3,1));
    tbl.push_back(v(0,1,0,0, 3, 0,0,0, 3,1));
    tbl.push_back(v(0,0,0,0, 4, 0,0,0, 3,1));
    tbl.push_back(v(0,0,1,1, 1, 0,0,0, 0,0));
    tbl.push_back(v(0,1,1,0, 3, 0,1,1, 0,0));
    tbl.push_back(v(0,0,0,0,11, 1,1,0, 0,0));
    tbl.push_back(v(0,0,0,0, 1, 0,0,0, 1,0));
    tbl.push_back(v(0,1,1,0, 3, 0,1,1, 1,0));
    tbl.push_back(v(0,0,1,0, 5, 0,1,0, 1,0));
    tbl.push_back(v(1,0,1,0, 1, 0,0,0, 0,0));
    tbl.push_back(v(0,1,1,0, 3, 0,1,1, 0,0));
    tbl.push_back(v(0,0,1,0,12, 0,0,0, 1,0));

    #1;
    foreach (tbl[i]) begin
      a_rst = tbl[i].rst; a_trig = tbl[i].trig; a_en = tbl[i].en; a_clr = tbl[i].clr;
      step(tbl[i].ncyc);
      chk($sformatf("table[%0d] {rdy,busy,expo,frame,missed}", i),
          32'({a_rdy, a_busy, a_expo, a_frame, a_missed}),
          32'({tbl[i].rdy, tbl[i].busy, tbl[i].expo, tbl[i].frame, tbl[i].missed}));
    end

    // Randomized traffic against the timeline model.
    a_rst = 1; a_clr = 0; a_trig = 0; a_en = 1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc > 2) begin
        a_rst = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 3) == 0) a_trig = ~a_trig;
        a_en  = ($urandom_range(0, 9) != 0);
        a_clr = ($urandom_range(0, 59) == 0);
      end
      @(posedge clk);
      model_step(a_rst, a_trig, a_en, a_clr);
      #1;
      exp_busy = (m_left > 0);
      el       = int'(A_TOTAL) - int'(m_left);
      exp_expo = exp_busy && (el < int'(A_E));
      exp_rdy  = exp_busy && (el >= int'(A_E + A_R));
      chk($sformatf("random[%0d] {rdy,busy,expo,frame,missed}", cyc),
          32'({a_rdy, a_busy, a_expo, a_frame, a_missed}),
          32'({exp_rdy, exp_busy, exp_expo, m_frame, m_missed}));
    end
    a_rst = 1;

    // Missed counter saturation with long exposure/readout.
    step(2);
    b_rst = 0; b_trig = 1;
    step(2);
    b_trig = 0;
    step(4);
    chk("sat accepted busy", 32'(b_busy), 32'(1));
    for (int p = 0; p < 260; p++) begin
      b_trig = 1; step(3);
      b_trig = 0; step(3);
    end
    chk("sat missed_cnt", 32'(b_missed), 32'(255));
    chk("sat still busy, no frame", 32'({b_busy, b_frame}), 32'({1'b1, 8'd0}));
    b_trig = 1;
    step(2);
    b_clr = 1;
    step(1);
    b_clr = 0; b_trig = 0;
    chk("clear beats missed rise", 32'(b_missed), 32'(0));
    begin
      int i;
      for (i = 0; i < 6000; i++) begin
        if (!b_busy) break;
        step(1);
      end
      chk("sat frame ends within budget", 32'(b_busy), 32'(0));
    end
    chk("sat frame_cnt after completion", 32'({b_frame, b_missed}), 32'({8'd1, 8'd0}));
    b_rst = 1;

    // All phases one cycle long, trig held high.
    step(2);
    c_rst = 0; c_trig = 1;
    rdy_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (c_rdy) rdy_cnt++;
      chk($sformatf("min params cycle %0d {rdy,busy,expo}", i),
          32'({c_rdy, c_busy, c_expo}),
          32'({(i == 4), (i >= 2 && i <= 4), (i == 2)}));
    end
    chk("min params rdy pulse count", 32'(rdy_cnt), 32'(1));
    chk("min params counters", 32'({c_frame, c_missed}), 32'({8'd1, 8'd0}));
    c_trig = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/trig_rdy_responder.md
Name: trig_rdy_responder

Overview:
- Camera-side emulator for the structured-light trigger handshake: consumes the per-frame `trig` pulse from the projector pixel pipeline and returns a camera-ready `rdy` pulse after modelled exposure and readout times.
- Used in place of the physical camera to close the `trig`/`rdy` GPIO loop during bring-up and in-system self-test.
- Also counts completed frames and triggers that arrive while busy (missed).

Parameters:
- EXPO_CYC, 1000, exposure duration in clk cycles (1..65535)
- READ_CYC, 5000, readout duration in clk cycles (1..65535)
- RDY_W, 8, width of the rdy pulse in clk cycles (1..255)

Ports:
- clk  in  1  pixel clock; all logic on its rising edge
- rst  in  1  synchronous reset, active-high
- trig  in  1  trigger from pixel pipeline or GPIO, asynchronous to clk
- en  in  1  responder enable; sampled only in IDLE
- clr_stats  in  1  synchronous clear of frame_cnt and missed_cnt
- rdy  out  1  camera-ready pulse, high for exactly RDY_W cycles per accepted trigger
- busy  out  1  high in EXPOSE, READOUT and RDY
- exposing  out  1  high in EXPOSE only (strobe / LED)
- frame_cnt  out  8  completed frames; wraps 255->0
- missed_cnt  out  8  rising edges of trig ignored while busy; saturates at 255

Behaviour:
- Reset: state=IDLE, timer=0, sync flops=0, rdy=0, busy=0, exposing=0, frame_cnt=0, missed_cnt=0. Reset mid-operation aborts the frame with no rdy pulse and no count increment.
- Trigger input path:
  - trig passes through 2 FF synchronizer s1->s2, plus delayed copy s3.
  - trig_rise = s2 & ~s3.
  - Whole path is held at 0 by rst.
- FSM states IDLE, EXPOSE, READOUT, RDY. Timer is 16 bit, down-counting.
  - IDLE: if trig_rise & en -> EXPOSE, timer=EXPO_CYC-1. If trig_rise & ~en, stay in IDLE with no count change.
  - EXPOSE: timer!=0 -> timer-1. timer==0 -> READOUT, timer=READ_CYC-1.
  - READOUT: timer!=0 -> timer-1. timer==0 -> RDY, timer=RDY_W-1.
  - RDY: timer!=0 -> timer-1. timer==0 -> IDLE, frame_cnt+1.
- Outputs are registered, decoded from the next state, so they change on the same edge as the state.
  - rdy=1 iff state==RDY.
  - exposing=1 iff state==EXPOSE.
  - busy=1 iff state!=IDLE.
- Latency:
  - trig high before clk edge k -> state=EXPOSE after edge k+2.
  - rdy rises after edge k+2+EXPO_CYC+READ_CYC.
  - rdy stays high RDY_W cycles.
  - busy is high EXPO_CYC+READ_CYC+RDY_W cycles in total.
- trig_rise while state!=IDLE: ignored for FSM; missed_cnt+1 unless it is already 255.
  - This includes a rise in the final RDY cycle.
  - A rise in the same cycle the FSM returns to IDLE is missed, not accepted.
- A trig level held high produces one rise only; re-trigger needs a low of at least 1 cycle seen by the synchronizer.
- en deasserted while busy: current frame completes normally, including rdy and frame_cnt.
- clr_stats: both counters go to 0 on the next edge. Clear wins over a simultaneous increment. FSM is unaffected.
- Parameters of 1 are legal: the state lasts exactly 1 cycle.

Decomposition:
- Shared package trig_pkg:
  - state typedef (IDLE, EXPOSE, READOUT, RDY; 2 bit encoding 00/01/10/11)
  - TMR_W=16, CNT_W=8
- One sub-module edge_sync: 2 FF synchronizer plus rise detect, with sync reset. Reused for other GPIO inputs such as the pipeline's rdy sampling.

Test Plan (EXPO_CYC=4, READ_CYC=6, RDY_W=2 unless noted):
- Reset then single trig pulse of 3 cycles at edge 10 -> EXPOSE after edge 12, rdy high after edges 22-23, low after edge 24, busy high 12 cycles, frame_cnt=1, missed_cnt=0.
- Second trig rise during READOUT -> no extra rdy, missed_cnt=1. Trig rise 2 cycles after busy falls -> accepted, frame_cnt=2.
- en=0 with trig pulses in IDLE -> rdy never asserts, counters stay 0. en dropped mid-EXPOSE -> frame completes, rdy pulses once.
- 260 triggers all landing while busy, using EXPO_CYC=READ_CYC=2000 -> missed_cnt saturates at 255. clr_stats together with a missed rise -> missed_cnt=0.
- rst asserted during READOUT -> rdy/busy=0 next cycle, frame_cnt unchanged at 0. Following trig -> full normal sequence.
- EXPO_CYC=READ_CYC=RDY_W=1 with trig held high for 50 cycles -> exactly one rdy pulse, 1 cycle wide, rising after edge k+4. frame_cnt=1.
